abm_read_engine: RTL and testbench

- Consumes the one-cycle `start` pulse from the ABM send control block and returns one of its two `idle` inputs.
- On `start`, reads one complete ABM from a fixed source address in memory, using AXI4 INCR read bursts.
- Presents the read data as an AXI4-Stream toward the destination writer, and asserts TLAST on the final beat of the ABM.
- Two instances exist (idle_0 / idle_1), one per half of the ABM path.

---
 rtl/abm_read_engine.sv | 172 +++++++++++++++++
 tb/tb_abm_read_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abm_read_engine.sv
// abm_read_engine: on a start pulse, reads one ABM from SRC_ADDR with AXI4 INCR bursts and streams it out.
// Define ABM_READ_PERF_EN to add the saturating `cycles` busy-cycle counter port.
module abm_read_engine #(
    parameter int unsigned   DW              = 512,
    parameter int unsigned   AW              = 64,
    parameter logic [AW-1:0] SRC_ADDR        = '0,
    parameter int unsigned   ABM_BYTES       = 16384,
    parameter int unsigned   BURST_BEATS     = 64,
    parameter int unsigned   MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    output logic          idle,
    output logic          rd_error,
`ifdef ABM_READ_PERF_EN
    output logic [31:0]   cycles,
`endif
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY,
    output logic [DW-1:0] AXIS_OUT_TDATA,
    output logic          AXIS_OUT_TVALID,
    output logic          AXIS_OUT_TLAST,
    input  logic          AXIS_OUT_TREADY
);

    localparam int unsigned BPB         = DW / 8;
    localparam int unsigned BURST_BYTES = BPB * BURST_BEATS;
    localparam int unsigned NBURSTS     = ABM_BYTES / BURST_BYTES;
    localparam int unsigned NBEATS      = NBURSTS * BURST_BEATS;
    localparam int unsigned BCW         = $clog2(NBURSTS + 1);
    localparam int unsigned BTW         = $clog2(NBEATS + 1);
    localparam int unsigned OW          = 4;

    if (ABM_BYTES == 0 || (ABM_BYTES % BURST_BYTES) != 0) begin : g_bad_size
        $error("ABM_BYTES must be a nonzero multiple of BPB*BURST_BEATS");
    end
    if (BURST_BEATS < 1 || BURST_BEATS > 256 || BURST_BYTES > 4096) begin : g_bad_burst
        $error("BURST_BEATS must be 1..256 with BPB*BURST_BEATS <= 4096");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_outst
        $error("MAX_OUTSTANDING must be 1..15");
    end
    if ((SRC_ADDR % 4096) != 0) begin : g_bad_addr
        $error("SRC_ADDR must be 4 KB aligned");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

    state_e         state_q, state_d;
    logic           idle_q, idle_d;
    logic           err_q, err_d;
    logic [BCW-1:0] bursts_q, bursts_d;
    logic [BTW-1:0] beats_q, beats_d;
    logic [OW-1:0]  outst_q, outst_d;

    logic start_acc, ar_hs, r_xfer, r_last_hs, last_xfer;

    // AR channel is derived purely from registers, so it stays stable until ARREADY
    assign M_AXI_ARVALID = (state_q == S_ISSUE) && (outst_q < OW'(MAX_OUTSTANDING));
    assign M_AXI_ARADDR  = SRC_ADDR + AW'(bursts_q) * AW'(BURST_BYTES);
    assign M_AXI_ARLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BPB));
    assign M_AXI_ARBURST = 2'b01;

    // Zero-latency R -> AXIS pass-through, gated off while idle
    assign AXIS_OUT_TDATA  = M_AXI_RDATA;
    assign AXIS_OUT_TVALID = M_AXI_RVALID & ~idle_q;
    assign M_AXI_RREADY    = AXIS_OUT_TREADY & ~idle_q;
    assign AXIS_OUT_TLAST  = (beats_q == BTW'(NBEATS - 1));

    assign idle     = idle_q;
    assign rd_error = err_q;

    assign start_acc = start & idle_q;
    assign ar_hs     = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_xfer    = M_AXI_RVALID & AXIS_OUT_TREADY & ~idle_q;
    assign r_last_hs = r_xfer & M_AXI_RLAST;
    assign last_xfer = r_xfer & AXIS_OUT_TLAST;

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        err_d    = err_q;
        bursts_d = bursts_q;
        beats_d  = beats_q;
        outst_d  = outst_q;
        if (start_acc) begin
            state_d  = S_ISSUE;
            idle_d   = 1'b0;
            err_d    = 1'b0;
            bursts_d = '0;
            beats_d  = '0;
            outst_d  = '0;
        end else if (!idle_q) begin
            if (ar_hs) begin
                bursts_d = bursts_q + BCW'(1);
            end
            case ({ar_hs, r_last_hs})
                2'b10:   outst_d = outst_q + OW'(1);
                2'b01:   outst_d = outst_q - OW'(1);
                default: outst_d = outst_q;
            endcase
            if (r_xfer) begin
                beats_d = beats_q + BTW'(1);
                if (M_AXI_RRESP != 2'b00) begin
                    err_d = 1'b1;
                end
            end
            case (state_q)
                S_ISSUE: if (ar_hs && bursts_q == BCW'(NBURSTS - 1)) state_d = S_DONE;
                default: state_d = state_q;
            endcase
            // TLAST completes the ABM regardless of which AR state we are in
            if (last_xfer) begin
                idle_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
            bursts_q <= '0;
            beats_q  <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            err_q    <= err_d;
            bursts_q <= bursts_d;
            beats_q  <= beats_d;
            outst_q  <= outst_d;
        end
    end

`ifdef ABM_READ_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start_acc) begin
            cycles_d = '0;
        end else if (!idle_q && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_abm_read_engine.sv
// Scoreboard bench for abm_read_engine: directed transfers against a small AXI memory model.
module tb_abm_read_engine;

    localparam int unsigned   DW     = 512;
    localparam int unsigned   AW     = 64;
    localparam int unsigned   BB     = 64;
    localparam int unsigned   NBEATS = 256;
    localparam int unsigned   MAXO   = 2;
    localparam logic [AW-1:0] SRC    = 64'h1000_0000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn, start;
    logic          idle, rd_error;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE;
    logic [1:0]    M_AXI_ARBURST;
    logic          M_AXI_ARVALID, M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic          AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TREADY;
`ifdef ABM_READ_PERF_EN
    logic [31:0]   cycles;
`endif

    int checks = 0;
    int failures = 0;

    beat_t         exp_q[$];
    logic [AW-1:0] ar_exp[$];

    bit arready_en = 1'b1, arready_toggle = 1'b0, rvalid_en = 1'b1, tready_toggle = 1'b0;
    int err_beat = -1;
    int rbeat_total = 0;
    int ar_count = 0;

    always #5 clk = ~clk;

    abm_read_engine #(
        .DW(DW), .AW(AW), .SRC_ADDR(SRC), .ABM_BYTES(16384),
        .BURST_BEATS(BB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .idle(idle), .rd_error(rd_error),
`ifdef ABM_READ_PERF_EN
        .cycles(cycles),
`endif
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
        .AXIS_OUT_TLAST(AXIS_OUT_TLAST), .AXIS_OUT_TREADY(AXIS_OUT_TREADY)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream and AR addresses for one full ABM starting at 0x1000_0000
    task automatic queue_expect();
        beat_t b;
        for (int i = 0; i < NBEATS; i++) begin
            b.data = mem_word(SRC + AW'(i * 64));
            b.last = (i == NBEATS - 1);
            exp_q.push_back(b);
        end
        ar_exp.push_back(64'h1000_0000);
        ar_exp.push_back(64'h1000_1000);
        ar_exp.push_back(64'h1000_2000);
        ar_exp.push_back(64'h1000_3000);
        ar_count = 0;
        rbeat_total = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk({name, "_complete"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle_on_last"}, 64'(idle), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk({name, "_idle_after"}, 64'(idle), 64'd1);
        chk({name, "_ar_total"}, 64'(ar_count), 64'd4);
    endtask

    // AXI slave model: R data for each accepted AR, in order; also checks the AR channel
    initial begin : mem_model
        logic [AW-1:0] fifo[$];
        logic [AW-1:0] ar_addr_p, wait_addr, a, e;
        int  beat = 0;
        bit  ar_p = 1'b0, r_p = 1'b0, wait_p = 1'b0;
        forever begin
            @(negedge clk);
            if (ar_p) fifo.push_back(ar_addr_p);
            if (r_p) begin
                rbeat_total++;
                beat++;
                if (beat == BB) begin
                    beat = 0;
                    fifo.delete(0);
                end
            end
            M_AXI_ARREADY   = arready_toggle ? ~M_AXI_ARREADY : arready_en;
            AXIS_OUT_TREADY = tready_toggle ? ~AXIS_OUT_TREADY : 1'b1;
            if (rvalid_en && fifo.size() > 0) begin
                a = fifo[0] + AW'(beat * 64);
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = mem_word(a);
                M_AXI_RLAST  = (beat == BB - 1);
                M_AXI_RRESP  = (rbeat_total == err_beat) ? 2'd2 : 2'd0;
            end else begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RDATA  = '0;
                M_AXI_RLAST  = 1'b0;
                M_AXI_RRESP  = 2'd0;
            end
            #1;
            if (!resetn) begin
                fifo.delete();
                beat = 0;
                ar_p = 1'b0;
                r_p = 1'b0;
                wait_p = 1'b0;
            end else begin
                if (wait_p) begin
                    chk("arvalid_hold", 64'(M_AXI_ARVALID), 64'd1);
                    chk("araddr_hold", M_AXI_ARADDR, wait_addr);
                end
                ar_p      = M_AXI_ARVALID && M_AXI_ARREADY;
                ar_addr_p = M_AXI_ARADDR;
                r_p       = M_AXI_RVALID && M_AXI_RREADY;
                wait_p    = M_AXI_ARVALID && !M_AXI_ARREADY;
                wait_addr = M_AXI_ARADDR;
                if (ar_p) begin
                    ar_count++;
                    if (ar_exp.size() == 0) begin
                        chk("ar_unexpected", M_AXI_ARADDR, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = ar_exp.pop_front();
                        chk("araddr", M_AXI_ARADDR, e);
                    end
                    chk("arlen", 64'(M_AXI_ARLEN), 64'd63);
                    chk("arsize", 64'(M_AXI_ARSIZE), 64'd6);
                    chk("arburst", 64'(M_AXI_ARBURST), 64'd1);
                end
            end
        end
    end

    // Scoreboard monitor: pops one expected beat per accepted stream transfer
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra_beat: got data %0h last %0b, expected no beat",
                             AXIS_OUT_TDATA[63:0], AXIS_OUT_TLAST);
                end else begin
                    e = exp_q.pop_front();
                    if (AXIS_OUT_TDATA !== e.data || AXIS_OUT_TLAST !== e.last) begin
                        failures++;
                        $display("FAIL stream_beat: got data %0h last %0b, expected data %0h last %0b",
                                 AXIS_OUT_TDATA[63:0], AXIS_OUT_TLAST, e.data[63:0], e.last);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        resetn = 1'b0;
        start  = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = '0;
        M_AXI_RRESP = 2'd0;
        M_AXI_RLAST = 1'b0;
        AXIS_OUT_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("reset_rd_error", 64'(rd_error), 64'd0);
        chk("reset_tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
`ifdef ABM_READ_PERF_EN
        chk("reset_cycles", 64'(cycles), 64'd0);
`endif
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // all-ready transfer
        queue_expect();
        do_start();
        chk("t1_idle_after_start", 64'(idle), 64'd0);
        wait_done("t1");
`ifdef ABM_READ_PERF_EN
        chk("t1_cycles_ge_257", 64'(cycles >= 32'd257), 64'd1);
`endif

        // R withheld: only MAX_OUTSTANDING ARs go out
        rvalid_en = 1'b0;
        queue_expect();
        do_start();
        repeat (20) @(negedge clk);
        #3;
        chk("t2_ar_limited", 64'(ar_count), 64'd2);
        chk("t2_arvalid_low", 64'(M_AXI_ARVALID), 64'd0);
        rvalid_en = 1'b1;
        wait_done("t2");

        // TREADY and ARREADY toggling every cycle
        tready_toggle = 1'b1;
        arready_toggle = 1'b1;
        queue_expect();
        do_start();
        wait_done("t3");
        tready_toggle = 1'b0;
        arready_toggle = 1'b0;
        arready_en = 1'b1;

        // second start mid-transfer is ignored
        queue_expect();
        do_start();
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4");

        // error response on beat 100
        err_beat = 100;
        queue_expect();
        do_start();
        wait_done("t5");
        chk("t5_rd_error_set", 64'(rd_error), 64'd1);
        err_beat = -1;

        // next start clears the sticky error
        queue_expect();
        do_start();
        chk("t6_rd_error_cleared", 64'(rd_error), 64'd0);
        wait_done("t6");
        chk("t6_rd_error_end", 64'(rd_error), 64'd0);

        // reset in the middle of burst 2
        err_beat = 10;
        queue_expect();
        do_start();
        n = 0;
        while (rbeat_total < 70 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t7_reached_burst2", 64'(rbeat_total >= 70), 64'd1);
        chk("t7_rd_error_before", 64'(rd_error), 64'd1);
        @(negedge clk);
        resetn = 1'b0;
        exp_q.delete();
        ar_exp.delete();
        @(posedge clk);
        #1;
        chk("t7_idle", 64'(idle), 64'd1);
        chk("t7_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        chk("t7_rd_error", 64'(rd_error), 64'd0);
`ifdef ABM_READ_PERF_EN
        chk("t7_cycles", 64'(cycles), 64'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        err_beat = -1;
        repeat (3) @(negedge clk);

        // clean transfer after reset
        queue_expect();
        do_start();
        wait_done("t8");
        chk("t8_rd_error", 64'(rd_error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
